// File: rtl/dvsd_adder_pkg.sv
// Shared constants and FSM encoding for the slice-serial adder family.
package dvsd_adder_pkg;

  localparam int SLICE_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dvsd_adder_12bit.sv
// One 12-bit slice adder shared across all slices of the sequential adder.
// Operands are isolated to zero while CE is low so the adder stays quiet between runs.
module dvsd_adder_12bit
  import dvsd_adder_pkg::*;
(
  input  logic               CE,
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               Cin,
  output logic [SLICE_W-1:0] s,
  output logic               Cout
);

  logic [SLICE_W:0] sum;

  always_comb begin
    sum = '0;
    if (CE) begin
      sum = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, Cin};
    end
  end

  assign s    = sum[SLICE_W-1:0];
  assign Cout = sum[SLICE_W];

endmodule

// File: rtl/dvsd_adder_seq36.sv
// Slice-serial W-bit adder: one 12-bit slice per enabled cycle, valid/ready on both sides.
// Optional subtract mode is enabled with macro DVSD_ADDER_SEQ_SUB_EN (adds input 'sub').
module dvsd_adder_seq36
  import dvsd_adder_pkg::*;
#(
  parameter int NSLICE = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      CE,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SLICE_W*NSLICE-1:0] A,
  input  logic [SLICE_W*NSLICE-1:0] B,
  input  logic                      Cin,
`ifdef DVSD_ADDER_SEQ_SUB_EN
  input  logic                      sub,
`endif
  output logic [SLICE_W*NSLICE-1:0] S,
  output logic                      Cout,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int W  = SLICE_W * NSLICE;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  state_t              state;
  logic [KW-1:0]       k;
  logic                carry;
  logic [W-1:0]        a_r;
  logic [W-1:0]        b_r;
  logic                accept;
  logic                run_en;
  logic [SLICE_W-1:0]  a_sl;
  logic [SLICE_W-1:0]  b_sl;
  logic [SLICE_W-1:0]  sum_sl;
  logic                c_sl;
  logic [W-1:0]        b_in;
  logic                c_init;

  assign in_ready  = (state == IDLE) && CE;
  assign accept    = in_valid && in_ready;
  assign run_en    = CE && (state == RUN);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

`ifdef DVSD_ADDER_SEQ_SUB_EN
  // Two's-complement subtract: A + ~B + 1.
  assign b_in   = sub ? ~B : B;
  assign c_init = sub ? 1'b1 : Cin;
`else
  assign b_in   = B;
  assign c_init = Cin;
`endif

  assign a_sl = a_r[SLICE_W*k +: SLICE_W];
  assign b_sl = b_r[SLICE_W*k +: SLICE_W];

  dvsd_adder_12bit u_slice (
    .CE   (run_en),
    .a    (a_sl),
    .b    (b_sl),
    .Cin  (carry),
    .s    (sum_sl),
    .Cout (c_sl)
  );

  // Operand capture: data-only registers, loaded at accept, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= A;
      b_r <= b_in;
    end
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      carry <= 1'b0;
      S     <= '0;
      Cout  <= 1'b0;
    end else if (CE) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            k     <= '0;
            carry <= c_init;
            state <= RUN;
          end
        end
        RUN: begin
          S[SLICE_W*k +: SLICE_W] <= sum_sl;
          carry                   <= c_sl;
          if (k == K_LAST) begin
            Cout  <= c_sl;
            k     <= '0;
            state <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dvsd_adder_seq36.sv
// Self-checking bench for dvsd_adder_seq36: directed corner cases plus random sums vs. an arithmetic model.
module tb_dvsd_adder_seq36;

  localparam int NSLICE = 3;
  localparam int W      = 12 * NSLICE;
  localparam int TMO    = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         CE;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
`ifdef DVSD_ADDER_SEQ_SUB_EN
  logic         sub = 1'b0;
`endif
  logic [W-1:0] S;
  logic         Cout;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dvsd_adder_seq36 #(.NSLICE(NSLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .CE        (CE),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
`ifdef DVSD_ADDER_SEQ_SUB_EN
    .sub       (sub),
`endif
    .S         (S),
    .Cout      (Cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_w();
    return W'({$urandom(), $urandom()});
  endfunction

  // Issue one request from IDLE, scramble inputs after accept, wait for the result, hand it off.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       output logic [W-1:0] s_o, output logic c_o, output int lat_o);
    A = a; B = b; Cin = cin; in_valid = 1'b1; out_ready = 1'b1; CE = 1'b1;
    tick();
    in_valid = 1'b0; A = rnd_w(); B = rnd_w(); Cin = 1'($urandom());
    lat_o = 0;
    while (!out_valid && lat_o < TMO) begin
      tick();
      lat_o++;
    end
    s_o = S;
    c_o = Cout;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; CE = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Cin = 1'b0;
    tick(); tick();
    checks++;
    if (S !== '0 || Cout !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: S=%h Cout=%b out_valid=%b busy=%b, want all 0", S, Cout, out_valid, busy);
    end
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [3] = '{36'd4, 36'h000000FFF, 36'hFFFFFFFFF};
    logic [W-1:0] tb [3] = '{36'd2, 36'd1, 36'd1};
    logic         tc [3] = '{1'b1, 1'b0, 1'b0};
    logic [W-1:0] es [3] = '{36'd7, 36'h000001000, 36'd0};
    logic         ec [3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] s;
    logic         c;
    int           lat;
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb[i], tc[i], s, c, lat);
      checks++;
      if (s !== es[i] || c !== ec[i]) begin
        errors++;
        $display("FAIL directed_%0d: S=%h Cout=%b want S=%h Cout=%b", i, s, c, es[i], ec[i]);
      end
      checks++;
      if (lat != NSLICE) begin
        errors++;
        $display("FAIL directed_latency_%0d: got %0d want %0d", i, lat, NSLICE);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s;
    logic         cin, c;
    logic [W:0]   exp;
    int           lat;
    for (int i = 0; i < 20; i++) begin
      a = rnd_w(); b = rnd_w(); cin = 1'($urandom());
      if (i == 0) begin a = '1; b = '1; cin = 1'b1; end
      exp = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL random_ready_%0d: in_ready=%b want 1", i, in_ready);
      end
      do_op(a, b, cin, s, c, lat);
      checks++;
      if ({c, s} !== exp || lat != NSLICE) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h cin=%b got Cout=%b S=%h lat=%0d want Cout=%b S=%h lat=%0d",
                 i, a, b, cin, c, s, lat, exp[W], exp[W-1:0], NSLICE);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, s0;
    logic         c0;
    logic [W:0]   exp;
    int           lat;
    a = rnd_w(); b = rnd_w();
    exp = {1'b0, a} + {1'b0, b} + (W+1)'(1);
    A = a; B = b; Cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0; CE = 1'b1;
    tick();
    lat = 0;
    while (!out_valid && lat < TMO) begin tick(); lat++; end
    s0 = S; c0 = Cout;
    checks++;
    if ({c0, s0} !== exp) begin
      errors++;
      $display("FAIL bp_result: Cout=%b S=%h want Cout=%b S=%h", c0, s0, exp[W], exp[W-1:0]);
    end
    A = rnd_w(); B = rnd_w();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (S !== s0 || Cout !== c0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: S=%h Cout=%b out_valid=%b in_ready=%b want S=%h Cout=%b 1 0",
                 i, S, Cout, out_valid, in_ready, s0, c0);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic [W:0]   exp;
    int           lat;
    in_valid = 1'b1; out_ready = 1'b1; CE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = rnd_w(); b = rnd_w();
      A = a; B = b; Cin = 1'b0;
      exp = {1'b0, a} + {1'b0, b};
      tick();
      lat = 0;
      while (!out_valid && lat < TMO) begin tick(); lat++; end
      checks++;
      if ({Cout, S} !== exp || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_done_%0d: Cout=%b S=%h in_ready=%b want Cout=%b S=%h in_ready=0",
                 i, Cout, S, in_ready, exp[W], exp[W-1:0]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_handoff_%0d: out_valid=%b in_ready=%b want 0 1", i, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_ce_stall();
    logic [W-1:0] a, b;
    logic [W:0]   exp;
    int           lat;
    a = 36'h000FFFFFF; b = rnd_w();
    exp = {1'b0, a} + {1'b0, b} + (W+1)'(1);
    A = a; B = b; Cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1; CE = 1'b1;
    tick();
    in_valid = 1'b0; A = rnd_w(); B = rnd_w();
    lat = 0;
    while (!out_valid && lat < TMO) begin
      tick();
      lat++;
      CE = (lat >= 1 && lat < 4) ? 1'b0 : 1'b1;
    end
    checks++;
    if ({Cout, S} !== exp || lat != NSLICE + 3) begin
      errors++;
      $display("FAIL ce_stall: Cout=%b S=%h lat=%0d want Cout=%b S=%h lat=%0d",
               Cout, S, lat, exp[W], exp[W-1:0], NSLICE + 3);
    end
    CE = 1'b0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ce_stall_done_hold: out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    CE = 1'b1;
    tick();
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] s;
    logic         c;
    int           lat;
    A = 36'h123456789; B = 36'h0FEDCBA98; Cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1; CE = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (S !== '0 || Cout !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_run: S=%h Cout=%b out_valid=%b busy=%b in_ready=%b want 0 0 0 0 1",
               S, Cout, out_valid, busy, in_ready);
    end
    A = '1; B = 36'd1; Cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < TMO) begin tick(); lat++; end
    CE = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; CE = 1'b1;
    checks++;
    if (S !== '0 || Cout !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_done_ce0: S=%h Cout=%b out_valid=%b busy=%b want all 0", S, Cout, out_valid, busy);
    end
    do_op(36'd10, 36'd20, 1'b0, s, c, lat);
    checks++;
    if (s !== 36'd30 || c !== 1'b0 || lat != NSLICE) begin
      errors++;
      $display("FAIL after_abort: S=%h Cout=%b lat=%0d want S=1e Cout=0 lat=%0d", s, c, lat, NSLICE);
    end
  endtask

`ifdef DVSD_ADDER_SEQ_SUB_EN
  task automatic test_sub();
    logic [W-1:0] s, a, b;
    logic         c;
    int           lat;
    sub = 1'b1;
    do_op(36'd5, 36'd7, 1'b0, s, c, lat);
    checks++;
    if (s !== 36'hFFFFFFFFE || c !== 1'b0) begin
      errors++;
      $display("FAIL sub_5_7: S=%h Cout=%b want S=ffffffffe Cout=0", s, c);
    end
    for (int i = 0; i < 6; i++) begin
      a = rnd_w(); b = rnd_w();
      do_op(a, b, 1'($urandom()), s, c, lat);
      checks++;
      if (s !== W'(a - b) || c !== (a >= b)) begin
        errors++;
        $display("FAIL sub_rand_%0d: a=%h b=%h S=%h Cout=%b want S=%h Cout=%b",
                 i, a, b, s, c, W'(a - b), (a >= b));
      end
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_ce_stall();
    test_reset_abort();
`ifdef DVSD_ADDER_SEQ_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvsd_adder_seq36.md
DVSD_ADDER_SEQ36 -- requirements
Module: dvsd_adder_seq36

Interface
REQ-001 SHALL have parameter NSLICE, default 3: number of 12-bit slices; operand width W = 12*NSLICE.
REQ-002 SHALL have port clk, input, 1: single rising-edge clock.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port CE, input, 1: clock enable; when 0, all state holds.
REQ-005 SHALL have port in_valid, input, 1: operand request.
REQ-006 SHALL have port in_ready, output, 1: block accepts an operand request.
REQ-007 SHALL have ports A and B, input, W each: addends.
REQ-008 SHALL have port Cin, input, 1: carry into slice 0.
REQ-009 SHALL have port S, output, W: registered sum.
REQ-010 SHALL have port Cout, output, 1: carry out of the final slice.
REQ-011 SHALL have port out_valid, output, 1: S and Cout hold a result.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port busy, output, 1: high whenever the FSM is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE with CE=1.
REQ-016 SHALL accept a request when in_valid&&in_ready: capture A, B and Cin; clear slice index k to 0; go RUN.
REQ-017 SHALL, in RUN with CE=1, add slice k of A and B with the carry register on the shared 12-bit adder, write S[12k+11:12k], update the carry register and increment k.
REQ-018 SHALL, for an accept at edge E0, register slice k at edge E0+k+1 and raise out_valid after edge E0+NSLICE (latency NSLICE cycles); on the last slice, state goes DONE and Cout takes the final carry.
REQ-019 SHALL hold S, Cout and out_valid stable in DONE until out_valid&&out_ready&&CE, then go IDLE.
REQ-020 SHALL not accept a new request in the same cycle as a result handoff; in_ready rises in the following cycle.
REQ-021 SHALL, when CE=0, freeze the state, k, carry and outputs; no handshake completes, so latency stretches by the number of CE-low cycles.
REQ-022 SHALL ignore in_valid outside IDLE; A, B and Cin need not be held after accept.
REQ-023 SHALL wrap modulo 2^W, with the overflow bit on Cout only.

Reset
REQ-024 SHALL, on rst=1 at a clock edge and regardless of CE, go IDLE with S=0, Cout=0, out_valid=0, busy=0, k=0 and carry=0.
REQ-025 SHALL abort an in-flight operation on reset mid-RUN or mid-DONE and discard its result.

Configuration
REQ-026 SHALL, with macro DVSD_ADDER_SEQ_SUB_EN defined, add input sub (1 bit, captured at accept); when sub=1, invert B and force the initial carry to 1, giving S=A-B and Cout=1 when A>=B.
REQ-027 SHALL, without DVSD_ADDER_SEQ_SUB_EN, have no sub port and perform addition only.

Structure
REQ-028 SHALL take the slice width 12 and the state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2 from a shared package, dvsd_adder_pkg.
REQ-029 SHALL instantiate exactly one dvsd_adder_12bit as its datapath sub-module, with its CE tied to the RUN-state enable and its Cin driven by the carry register.

Verification
REQ-030 SHALL cover: A=4, B=2, Cin=1 -> S=7, Cout=0, out_valid exactly 3 cycles after accept.
REQ-031 SHALL cover: A=36'h000000FFF, B=1, Cin=0 -> S=36'h000001000, Cout=0 (carry crosses a slice boundary).
REQ-032 SHALL cover: A=36'hFFFFFFFFF, B=1, Cin=0 -> S=0, Cout=1.
REQ-033 SHALL cover: out_ready low for 5 cycles in DONE -> S, Cout and out_valid stable; in_ready=0 throughout.
REQ-034 SHALL cover: CE low for 3 cycles during RUN -> result correct, latency 6 cycles; rst pulse at RUN k=1 -> IDLE and all outputs 0 next cycle.
REQ-035 SHALL cover, with DVSD_ADDER_SEQ_SUB_EN: sub=1, A=5, B=7 -> S=36'hFFFFFFFFE, Cout=0.
